cargador_prog: RTL and testbench

CARGADOR_PROG -- requirements
Module: cargador_prog

---
 rtl/cargador_prog.sv | 181 ++++++++++++++++++
 tb/tb_cargador_prog.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cargador_prog.sv
// cargador_prog: program loader. It receives a byte stream in this order:
// a 16-bit big-endian word count N, then N 16-bit words (each sent high byte
// first), then one XOR checksum byte. It writes the words to program memory
// and holds the processor in reset until a load completes without error.
//
// FSM states
//   state  | meaning
//   IDLE   | no session; waiting for start; cpu_reset reflects the last outcome
//   LEN_HI | waiting for the high byte of the word count
//   LEN_LO | waiting for the low byte of the word count; the count is checked here
//   W_HI   | waiting for the high byte of the current word
//   W_LO   | waiting for the low byte; the word is written in the following cycle
//   CHK    | waiting for the checksum byte
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   start              : request a load session (sampled only in IDLE)
//   byte_in/byte_valid : stream input; byte_ready is its handshake
//   mem_we/addr/wd     : program memory write port
//   cpu_reset          : processor reset hold
//   busy/done/error    : session status (done is a pulse, error is sticky)
module cargador_prog #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wd,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int          IDLE_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_W_HI,
    S_W_LO,
    S_CHK
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [7:0]        hi_byte;
  logic [7:0]        acc;
  logic [16:0]       word_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              mem_we_q;

  logic              xfer;
  logic              sess_start;
  logic              wr_word;
  logic              sess_ok;
  logic              sess_fail;
  logic              len_bad;
  logic              last_word;
  logic              timeout;
  logic [15:0]       n_rx;

  assign busy       = (state != S_IDLE);
  assign byte_ready = busy;
  assign xfer       = byte_valid && byte_ready;

  assign n_rx      = {len_hi, byte_in};
  assign len_bad   = (n_rx == 16'd0) || (32'(n_rx) > MAX_WORDS);
  assign last_word = ((word_cnt + 17'd1) == {1'b0, len});
  assign timeout   = busy && !xfer && (idle_cnt == IDLE_W'(TIMEOUT - 1));

  // A reset arriving while a write is already registered must not let that
  // write reach the memory, so the strobe is masked by reset directly.
  assign mem_we = mem_we_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sess_start = 1'b0;
    wr_word    = 1'b0;
    sess_ok    = 1'b0;
    sess_fail  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt  = S_LEN_HI;
          sess_start = 1'b1;
        end
      end
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (xfer) begin
          if (len_bad) begin
            state_nxt = S_IDLE;
            sess_fail = 1'b1;
          end else begin
            state_nxt = S_W_HI;
          end
        end
      end
      S_W_HI: if (xfer) state_nxt = S_W_LO;
      S_W_LO: begin
        if (xfer) begin
          wr_word   = 1'b1;
          state_nxt = last_word ? S_CHK : S_W_HI;
        end
      end
      S_CHK: begin
        if (xfer) begin
          state_nxt = S_IDLE;
          if (byte_in == acc) sess_ok   = 1'b1;
          else                sess_fail = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // Timeout only fires in cycles without a transfer, so it never collides
    // with the transfer decisions above.
    if (timeout) begin
      state_nxt = S_IDLE;
      sess_fail = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi    <= '0;
      len       <= '0;
      hi_byte   <= '0;
      acc       <= '0;
      word_cnt  <= '0;
      idle_cnt  <= '0;
      mem_we_q  <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      mem_we_q <= wr_word;
      done     <= sess_ok;

      if (sess_start || xfer || timeout) idle_cnt <= '0;
      else if (busy)                     idle_cnt <= idle_cnt + 1'b1;

      if (xfer && state == S_LEN_HI) len_hi <= byte_in;
      if (xfer && state == S_LEN_LO) len    <= n_rx;
      if (xfer && state == S_W_HI)   hi_byte <= byte_in;
      if (xfer && (state == S_W_HI || state == S_W_LO)) acc <= acc ^ byte_in;

      if (wr_word) begin
        mem_addr <= word_cnt[ADDR_W-1:0];
        mem_wd   <= {hi_byte, byte_in};
        word_cnt <= word_cnt + 17'd1;
      end

      if (sess_start) begin
        error     <= 1'b0;
        cpu_reset <= 1'b1;
        word_cnt  <= '0;
        acc       <= '0;
      end
      if (sess_fail) error     <= 1'b1;
      if (sess_ok)   cpu_reset <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cargador_prog.sv
module tb_cargador_prog;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wd;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  cargador_prog #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  int n_checks    = 0;
  int n_fail      = 0;
  int writes_seen = 0;
  int done_seen   = 0;

  logic [ADDR_W+15:0] exp_q[$];
  logic [15:0]        wbuf[4];

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [ADDR_W+15:0] e;
    if (mem_we === 1'b1) begin
      writes_seen++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got addr=%0h data=%04h, expected no write", mem_addr, mem_wd);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wd} !== e) begin
          n_fail++;
          $display("FAIL write_data: got addr=%0h data=%04h, expected addr=%0h data=%04h",
                   mem_addr, mem_wd, e[ADDR_W+15:16], e[15:0]);
        end
      end
    end
    if (done === 1'b1) done_seen++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    byte_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic gap(input int max_gap);
    int g;
    if (max_gap > 0) begin
      g = $urandom_range(max_gap, 0);
      if (g > 0) idle_cycles(g);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    n_checks++;
    if (byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: byte %02h got byte_ready=%b expected 1", b, byte_ready);
    end
    step();
  endtask

  function automatic logic [7:0] xsum(input int n);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < n; i++) r = r ^ wbuf[i][15:8] ^ wbuf[i][7:0];
    return r;
  endfunction

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Sends a complete stream for wbuf[0..n-1] with random gaps up to max_gap.
  task automatic stream(input int n, input logic [7:0] chk, input int max_gap);
    logic [15:0] nn;
    nn = 16'(n);
    gap(max_gap); send_byte(nn[15:8]);
    gap(max_gap); send_byte(nn[7:0]);
    for (int i = 0; i < n; i++) begin
      gap(max_gap); send_byte(wbuf[i][15:8]);
      gap(max_gap);
      exp_q.push_back({ADDR_W'(i), wbuf[i]});
      send_byte(wbuf[i][7:0]);
    end
    gap(max_gap); send_byte(chk);
    byte_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    step(); step();
    @(negedge clk);
    n_checks += 8;
    if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL rst_byte_ready: got %b expected 0", byte_ready); end
    if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
    if (mem_addr !== '0)     begin n_fail++; $display("FAIL rst_mem_addr: got %0h expected 0", mem_addr); end
    if (mem_wd !== 16'h0)    begin n_fail++; $display("FAIL rst_mem_wd: got %04h expected 0", mem_wd); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0)       begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
    if (error !== 1'b0)      begin n_fail++; $display("FAIL rst_error: got %b expected 0", error); end
    if (cpu_reset !== 1'b1)  begin n_fail++; $display("FAIL rst_cpu_reset: got %b expected 1", cpu_reset); end
    step();
    reset = 1'b0;
    byte_valid = 1'b1; byte_in = 8'h55;
    step(); step();
    @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL idle_valid_busy: got %b expected 0", busy); end
    if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL idle_valid_ready: got %b expected 0", byte_ready); end
    step();
    byte_valid = 1'b0;
  endtask

  task automatic test_good_load();
    int w0, d0;
    w0 = writes_seen; d0 = done_seen;
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    start = 1'b1;        // held high into the session: must be ignored while busy
    step();
    stream(2, 8'h40, 0);
    start = 1'b0;
    @(negedge clk);
    n_checks += 4;
    if (done !== 1'b1)      begin n_fail++; $display("FAIL good_done: got %b expected 1", done); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL good_busy: got %b expected 0", busy); end
    if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL good_cpu_reset: got %b expected 0", cpu_reset); end
    if (error !== 1'b0)     begin n_fail++; $display("FAIL good_error: got %b expected 0", error); end
    step(); step();
    @(negedge clk);
    n_checks += 5;
    if (done !== 1'b0)            begin n_fail++; $display("FAIL good_done_pulse: got %b expected 0", done); end
    if (cpu_reset !== 1'b0)       begin n_fail++; $display("FAIL good_cpu_reset_hold: got %b expected 0", cpu_reset); end
    if (writes_seen - w0 !== 2)   begin n_fail++; $display("FAIL good_writes: got %0d expected 2", writes_seen - w0); end
    if (done_seen - d0 !== 1)     begin n_fail++; $display("FAIL good_done_count: got %0d expected 1", done_seen - d0); end
    if (exp_q.size() !== 0)       begin n_fail++; $display("FAIL good_pending: got %0d expected 0", exp_q.size()); end
    step();
  endtask

  task automatic test_bad_checksum();
    int w0, d0;
    w0 = writes_seen; d0 = done_seen;
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    do_start();
    stream(2, 8'h41, 0);
    @(negedge clk);
    n_checks += 4;
    if (error !== 1'b1)     begin n_fail++; $display("FAIL chk_error: got %b expected 1", error); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL chk_done: got %b expected 0", done); end
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL chk_cpu_reset: got %b expected 1", cpu_reset); end
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL chk_busy: got %b expected 0", busy); end
    step(); step();
    @(negedge clk);
    n_checks += 3;
    if (writes_seen - w0 !== 2) begin n_fail++; $display("FAIL chk_writes: got %0d expected 2", writes_seen - w0); end
    if (done_seen - d0 !== 0)   begin n_fail++; $display("FAIL chk_done_count: got %0d expected 0", done_seen - d0); end
    if (error !== 1'b1)         begin n_fail++; $display("FAIL chk_error_sticky: got %b expected 1", error); end
    step();
  endtask

  task automatic test_bad_length();
    logic [15:0] lens[2];
    int w0;
    lens[0] = 16'h0000; lens[1] = 16'h0401;
    w0 = writes_seen;
    for (int k = 0; k < 2; k++) begin
      do_start();
      @(negedge clk);
      n_checks++;
      if (error !== 1'b0) begin n_fail++; $display("FAIL len_start_clears_error: got %b expected 0", error); end
      step();
      send_byte(lens[k][15:8]);
      send_byte(lens[k][7:0]);
      byte_valid = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (error !== 1'b1) begin n_fail++; $display("FAIL len_error n=%04h: got %b expected 1", lens[k], error); end
      if (busy !== 1'b0)  begin n_fail++; $display("FAIL len_busy n=%04h: got %b expected 0", lens[k], busy); end
      step();
    end
    // N = 2^ADDR_W is the largest legal count and must be accepted.
    do_start();
    send_byte(8'h04);
    send_byte(8'h00);
    byte_valid = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b1)  begin n_fail++; $display("FAIL len_max_busy: got %b expected 1", busy); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL len_max_error: got %b expected 0", error); end
    step();
    reset = 1'b1; step(); reset = 1'b0;
    step();
    @(negedge clk);
    n_checks++;
    if (writes_seen - w0 !== 0) begin n_fail++; $display("FAIL len_writes: got %0d expected 0", writes_seen - w0); end
    step();
  endtask

  task automatic test_timeout();
    int w0;
    w0 = writes_seen;
    do_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h12);
    byte_valid = 1'b0;
    repeat (TIMEOUT - 1) step();
    @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b1)  begin n_fail++; $display("FAIL to_early_busy: got %b expected 1", busy); end
    if (error !== 1'b0) begin n_fail++; $display("FAIL to_early_error: got %b expected 0", error); end
    step();
    @(negedge clk);
    n_checks += 4;
    if (error !== 1'b1)      begin n_fail++; $display("FAIL to_error: got %b expected 1", error); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL to_busy: got %b expected 0", busy); end
    if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL to_ready: got %b expected 0", byte_ready); end
    if (cpu_reset !== 1'b1)  begin n_fail++; $display("FAIL to_cpu_reset: got %b expected 1", cpu_reset); end
    step();
    n_checks++;
    if (writes_seen - w0 !== 0) begin n_fail++; $display("FAIL to_writes: got %0d expected 0", writes_seen - w0); end
  endtask

  task automatic test_back_to_back();
    int w0, d0;
    int gaps[2];
    gaps[0] = 0; gaps[1] = TIMEOUT - 2;
    for (int p = 0; p < 2; p++) begin
      w0 = writes_seen; d0 = done_seen;
      for (int i = 0; i < 3; i++) wbuf[i] = 16'($urandom);
      do_start();
      stream(3, xsum(3), gaps[p]);
      @(negedge clk);
      n_checks += 3;
      if (done !== 1'b1)      begin n_fail++; $display("FAIL b2b_done pass=%0d: got %b expected 1", p, done); end
      if (busy !== 1'b0)      begin n_fail++; $display("FAIL b2b_busy pass=%0d: got %b expected 0", p, busy); end
      if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL b2b_cpu_reset pass=%0d: got %b expected 0", p, cpu_reset); end
      step(); step();
      n_checks += 3;
      if (writes_seen - w0 !== 3) begin n_fail++; $display("FAIL b2b_writes pass=%0d: got %0d expected 3", p, writes_seen - w0); end
      if (done_seen - d0 !== 1)   begin n_fail++; $display("FAIL b2b_done_count pass=%0d: got %0d expected 1", p, done_seen - d0); end
      if (exp_q.size() !== 0)     begin n_fail++; $display("FAIL b2b_pending pass=%0d: got %0d expected 0", p, exp_q.size()); end
    end
  endtask

  task automatic test_reset_mid_load();
    int w0, d0;
    w0 = writes_seen;
    do_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    // The write for 1234 is now pending; reset lands in this cycle.
    reset = 1'b1;
    byte_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_we !== 1'b0) begin n_fail++; $display("FAIL mid_pending_we: got %b expected 0", mem_we); end
    step();
    @(negedge clk);
    n_checks += 8;
    if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL mid_byte_ready: got %b expected 0", byte_ready); end
    if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL mid_mem_we: got %b expected 0", mem_we); end
    if (mem_addr !== '0)     begin n_fail++; $display("FAIL mid_mem_addr: got %0h expected 0", mem_addr); end
    if (mem_wd !== 16'h0)    begin n_fail++; $display("FAIL mid_mem_wd: got %04h expected 0", mem_wd); end
    if (busy !== 1'b0)       begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
    if (done !== 1'b0)       begin n_fail++; $display("FAIL mid_done: got %b expected 0", done); end
    if (error !== 1'b0)      begin n_fail++; $display("FAIL mid_error: got %b expected 0", error); end
    if (cpu_reset !== 1'b1)  begin n_fail++; $display("FAIL mid_cpu_reset: got %b expected 1", cpu_reset); end
    step();
    reset = 1'b0;
    repeat (3) step();
    n_checks++;
    if (writes_seen - w0 !== 0) begin n_fail++; $display("FAIL mid_writes: got %0d expected 0", writes_seen - w0); end

    w0 = writes_seen; d0 = done_seen;
    wbuf[0] = 16'hC0DE; wbuf[1] = 16'h0FF1;
    do_start();
    stream(2, xsum(2), 0);
    @(negedge clk);
    n_checks += 2;
    if (done !== 1'b1)      begin n_fail++; $display("FAIL mid_reload_done: got %b expected 1", done); end
    if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL mid_reload_cpu_reset: got %b expected 0", cpu_reset); end
    step(); step();
    n_checks += 2;
    if (writes_seen - w0 !== 2) begin n_fail++; $display("FAIL mid_reload_writes: got %0d expected 2", writes_seen - w0); end
    if (exp_q.size() !== 0)     begin n_fail++; $display("FAIL mid_reload_pending: got %0d expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
